input_conditioner: RTL and testbench



---
 rtl/input_conditioner_pkg.sv | 11 +
 rtl/input_conditioner_if.sv | 11 +
 rtl/input_conditioner_debounce_channel.sv | 50 +++++
 rtl/input_conditioner.sv | 49 ++++
 tb/tb_input_conditioner.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the input conditioner front end.
package input_conditioner_pkg;
  localparam int NUM_CH        = 4;
  localparam int DB_CYCLES_DEF = 16;
  localparam int DIV_DEF       = 1000;

  // Counter width for a 0..n-1 count, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/input_conditioner_if.sv
// Raw inputs toward the conditioner, conditioned levels and strobe back out.
interface input_conditioner_if;
  import input_conditioner_pkg::*;

  logic [NUM_CH-1:0] raw;
  logic              a0, a1, a2, a3;
  logic              en;

  modport master (output raw, input a0, a1, a2, a3, en);
  modport slave  (input raw, output a0, a1, a2, a3, en);
endinterface

// File: rtl/input_conditioner_debounce_channel.sv
// One channel: 2-flop synchronizer, debounce counter and event-hold register.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic en,
  output logic a
);
  localparam int             CW      = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;

  always_comb begin
    sync_d = {sync_q[0], raw};
    deb_d  = deb_q;
    cnt_d  = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CNT_MAX) deb_d = sync_q[1];
      else                  cnt_d = cnt_q + 1'b1;
    end
    // A fresh rise beats a simultaneous strobe so the event survives one more period.
    if (deb_d && !deb_q) pend_d = 1'b1;
    else if (en)         pend_d = 1'b0;
    else                 pend_d = pend_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign a = deb_q | pend_q;
endmodule

// File: rtl/input_conditioner.sv
// Four debounced, event-holding channels plus the shared enable prescaler.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int DIV       = DIV_DEF
) (
  input logic                clk,
  input logic                rst,
  input_conditioner_if.slave io
);
  localparam int            PW   = cnt_w(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic              en_q, en_d;
  logic [NUM_CH-1:0] a_vec;

  always_comb begin
    en_d   = (pcnt_q == PMAX);
    pcnt_d = en_d ? '0 : pcnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
      en_q   <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      en_q   <= en_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_ch (
      .clk (clk),
      .rst (rst),
      .raw (io.raw[g]),
      .en  (en_q),
      .a   (a_vec[g])
    );
  end

  assign io.a0 = a_vec[0];
  assign io.a1 = a_vec[1];
  assign io.a2 = a_vec[2];
  assign io.a3 = a_vec[3];
  assign io.en = en_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: DB_CYCLES=4 with DIV=8 and DIV=1 side by side.
module tb_input_conditioner;
  import input_conditioner_pkg::*;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] raw;
  int         n_chk = 0, n_pass = 0;
  int         edge_n = 0;

  always #5 clk = ~clk;

  input_conditioner_if if0();
  input_conditioner_if if1();
  assign if0.raw = raw;
  assign if1.raw = raw;

  input_conditioner #(.DB_CYCLES(DB), .DIV(8)) dut0 (.clk(clk), .rst(rst), .io(if0.slave));
  input_conditioner #(.DB_CYCLES(DB), .DIV(1)) dut1 (.clk(clk), .rst(rst), .io(if1.slave));

  function automatic logic [3:0] a_of(input int d);
    return (d == 0) ? {if0.a3, if0.a2, if0.a1, if0.a0} : {if1.a3, if1.a2, if1.a1, if1.a0};
  endfunction

  function automatic logic en_of(input int d);
    return (d == 0) ? if0.en : if1.en;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: a level is accepted once DB consecutive synchronized samples
  // (raw seen two edges earlier) all disagree with it; events are held until
  // the strobe that follows; the strobe fires when edges-since-release is a multiple of DIV.
  logic [3:0] rq[$];
  bit         mdeb[4];
  bit         mpend[2][4];
  bit         men[2];
  int         mecnt;

  initial begin
    bit rise[4];
    bit en_prev;
    bit all_diff;
    int sz, dv;
    forever begin
      if (rst) begin
        rq = {};
        repeat (DB + 2) rq.push_back(4'h0);
        for (int c = 0; c < 4; c++) begin
          mdeb[c] = 0; mpend[0][c] = 0; mpend[1][c] = 0;
        end
        men[0] = 0; men[1] = 0; mecnt = 0;
      end else begin
        rq.push_back(raw);
        sz = rq.size();
        for (int c = 0; c < 4; c++) begin
          all_diff = 1;
          for (int j = 0; j < DB; j++)
            if (rq[sz-3-j][c] == mdeb[c]) all_diff = 0;
          rise[c] = all_diff && !mdeb[c];
          if (all_diff) mdeb[c] = !mdeb[c];
        end
        mecnt++;
        for (int d = 0; d < 2; d++) begin
          dv = (d == 0) ? 8 : 1;
          en_prev = men[d];
          men[d] = (mecnt % dv) == 0;
          for (int c = 0; c < 4; c++)
            mpend[d][c] = rise[c] ? 1'b1 : (en_prev ? 1'b0 : mpend[d][c]);
        end
        if (rq.size() > 32) void'(rq.pop_front());
      end
      @(posedge clk or posedge rst);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 4; c++)
          chk($sformatf("model_a%0d_dut%0d", c, d), a_of(d)[c], mdeb[c] | mpend[d][c]);
        chk($sformatf("model_en_dut%0d", d), en_of(d), men[d]);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    edge_n++;
  endtask

  task automatic align(input int p);
    while (edge_n % 8 != p) tick();
  endtask

  initial begin
    raw = 4'h0;
    // reset and strobe period
    repeat (3) @(negedge clk);
    chk("rst_outs_dut0", {if0.en, a_of(0)}, 0);
    chk("rst_outs_dut1", {if1.en, a_of(1)}, 0);
    rst = 1'b0;
    edge_n = 0;
    chk("en_before_edge1_div1", if1.en, 0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk($sformatf("en_div8_edge%0d", k), if0.en, (k % 8) == 0);
      chk($sformatf("en_div1_edge%0d", k), if1.en, 1);
    end

    // debounce latency on channel 0
    raw[0] = 1'b1;
    for (int r = 1; r <= 6; r++) begin
      tick();
      if (r == 5) chk("a0_edge5", if0.a0, 0);
      if (r == 6) chk("a0_edge6", {if0.a3, if0.a2, if0.a1, if0.a0}, 4'b0001);
    end
    repeat (10) tick();
    raw[0] = 1'b0;
    repeat (20) tick();

    // glitch rejection then acceptance on channel 1
    raw[1] = 1'b1;
    for (int r = 1; r <= 15; r++) begin
      tick();
      if (r == 3) raw[1] = 1'b0;
      chk("a1_short_pulse", if1.a1 | if0.a1, 0);
    end
    raw[1] = 1'b1;
    for (int r = 1; r <= 6; r++) begin
      tick();
      if (r == 4) raw[1] = 1'b0;
      if (r == 5) chk("a1_long_pulse_edge5", if0.a1, 0);
      if (r == 6) chk("a1_long_pulse_edge6", if0.a1, 1);
    end
    repeat (30) tick();

    // hold window on channel 2: deb falls at 11, strobe after 12, a2 falls at 13
    align(4);
    raw[2] = 1'b1;
    for (int r = 1; r <= 14; r++) begin
      tick();
      if (r == 5) raw[2] = 1'b0;
      case (r)
        5:  chk("a2_r5", if0.a2, 0);
        6:  chk("a2_r6", if0.a2, 1);
        11: chk("a2_r11", if0.a2, 1);
        12: chk("a2_r12", if0.a2, 1);
        13: chk("a2_r13", if0.a2, 0);
        14: chk("a2_r14", if0.a2, 0);
        default: ;
      endcase
    end
    repeat (10) tick();

    // rise coincides with a strobe on channel 3: held until the next strobe
    align(3);
    raw[3] = 1'b1;
    for (int r = 1; r <= 15; r++) begin
      tick();
      if (r == 5) raw[3] = 1'b0;
      case (r)
        5:  chk("a3_r5_en", {if0.en, if0.a3}, 2'b10);
        6:  chk("a3_r6", if0.a3, 1);
        13: chk("a3_r13", {if0.en, if0.a3}, 2'b11);
        14: chk("a3_r14", if0.a3, 0);
        default: ;
      endcase
    end
    repeat (10) tick();

    // reset mid-count with pend set and prescaler at 5
    align(4);
    raw[0] = 1'b1;
    for (int r = 1; r <= 9; r++) begin
      tick();
      if (r == 5) raw[0] = 1'b0;
    end
    chk("a0_before_midrst", {if0.en, if0.a0}, 2'b01);
    rst = 1'b1;
    #1;
    chk("midrst_outs_dut0", {if0.en, a_of(0)}, 0);
    chk("midrst_outs_dut1", {if1.en, a_of(1)}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    edge_n = 0;
    chk("en_after_rst_release", {if1.en, if0.en}, 0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("en_div8_post_rst_edge%0d", k), if0.en, (k % 8) == 0);
      chk($sformatf("en_div1_post_rst_edge%0d", k), if1.en, 1);
      chk("a_post_rst", a_of(0), 0);
    end
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
